ex_stage_reg: RTL and testbench
===============================

EX_STAGE_REG -- requirements
Module: ex_stage_reg

Interface
REQ-001 The block SHALL expose parameter ALU_OP_W, default 4, meaning width of the ALU operation code.
REQ-002 The block SHALL expose parameter RD_W, default 5, meaning width of the destination register index.
REQ-003 The block SHALL expose parameter RESET_ALU_OP, default 0, meaning the ALU code emitted for a bubble (NOP).
REQ-004 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
  clk  input  1  rising-edge clock
  rst  input  1  synchronous active-high reset
  flush  input  1  discard all held entries (branch/jump redirect)
  in_valid  input  1  upstream (ID) entry valid
  in_ready  output  1  block can accept an entry this cycle
  in_alu_op  input  ALU_OP_W  ALU operation
  in_alu_src  input  1  ALU operand-B select
  in_lui_src  input  1  LUI operand-A select
  in_rd  input  RD_W  destination register
  in_reg_write  input  1  register-file write enable
  out_valid  output  1  downstream (EX) entry valid
  out_ready  input  1  EX consumes the entry this cycle
  out_alu_op  output  ALU_OP_W  held ALU operation
  out_alu_src  output  1  held operand-B select
  out_lui_src  output  1  held operand-A select
  out_rd  output  RD_W  held destination register
  out_reg_write  output  1  held write enable
  bubble_cnt  output  16  count of cycles with out_valid=0 since reset

Function
REQ-005 The block SHALL be a two-entry skid buffer: main entry drives out_*, skid entry holds one extra entry.
REQ-006 State SHALL be EMPTY (no entries), ONE (main only), FULL (main+skid); encoded in a 2-bit register.
REQ-007 in_ready SHALL be a registered output, equal to 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-008 Input handshake SHALL occur when in_valid and in_ready are both 1; output handshake when out_valid and out_ready are both 1.
REQ-009 Transitions: EMPTY+in -> ONE; ONE+in only -> FULL; ONE+out only -> EMPTY; ONE+in+out -> ONE (main reloaded); FULL+out -> ONE (skid moves to main); otherwise hold.
REQ-010 Latency SHALL be 1 cycle: an entry accepted in EMPTY appears on out_* the next cycle.
REQ-011 Ordering SHALL be strictly FIFO; no entry is dropped or duplicated without flush or rst.
REQ-012 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-013 When out_valid=0, out_alu_op SHALL equal RESET_ALU_OP and out_alu_src, out_lui_src, out_rd, out_reg_write SHALL be 0.
REQ-014 While out_valid=1 and out_ready=0, out_* SHALL remain stable.
REQ-015 flush=1 SHALL drive the state to EMPTY next cycle, discarding main, skid and any same-cycle input; flush takes priority over both handshakes.
REQ-016 flush in EMPTY SHALL have no effect besides forcing in_ready=1 next cycle.
REQ-017 bubble_cnt SHALL increment each cycle out_valid=0, saturate at 16'hFFFF, and not wrap.

Reset
REQ-018 rst=1 at a rising edge SHALL set state EMPTY, in_ready=1, out_valid=0, out_* to bubble values (REQ-013), bubble_cnt=0.
REQ-019 rst SHALL take priority over flush and all handshakes, including mid-transfer in FULL.

Structure
REQ-020 A shared package SHALL hold the state enum (EMPTY, ONE, FULL) and a packed ex_ctrl_t payload struct parametrised by the defaults above.
REQ-021 One sub-module, ex_payload_reg (enable-loaded payload register with bubble reset value), SHALL be instantiated twice, for main and skid.

Verification
REQ-022 Reset then in_valid=1, alu_op=4'h3, rd=5'd7, out_ready=1 -> next cycle out_valid=1, out_alu_op=4'h3, out_rd=7.
REQ-023 out_ready=0, push A(op=1) then B(op=2) -> FULL, in_ready=0; out_ready=1 -> A then B on consecutive cycles.
REQ-024 FULL with A,B and flush=1 with in_valid=1 (op=5) -> next cycle out_valid=0, out_alu_op=RESET_ALU_OP, in_ready=1; op=5 never emitted.
REQ-025 ONE with simultaneous in (op=6) and out -> stays ONE, out_alu_op=6 next cycle.
REQ-026 rst asserted in FULL -> next cycle out_valid=0, in_ready=1, bubble_cnt=0.
REQ-027 Hold in_valid=0 for 70000 cycles after reset -> bubble_cnt=16'hFFFF and stays.

Source files
------------

// File: rtl/ex_stage_reg_pkg.sv
// Shared types for the EX pipeline register: occupancy states, default widths
// and the control payload carried from ID to EX.
package ex_stage_reg_pkg;

  localparam int unsigned ALU_OP_W_DEF     = 4;
  localparam int unsigned RD_W_DEF         = 5;
  localparam int unsigned RESET_ALU_OP_DEF = 0;
  localparam int unsigned CNT_W            = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ALU_OP_W_DEF-1:0] alu_op;
    logic                    alu_src;
    logic                    lui_src;
    logic [RD_W_DEF-1:0]     rd;
    logic                    reg_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    alu_op:    ALU_OP_W_DEF'(RESET_ALU_OP_DEF),
    alu_src:   1'b0,
    lui_src:   1'b0,
    rd:        '0,
    reg_write: 1'b0
  };

endpackage

// File: rtl/ex_stage_reg_if.sv
// ID->EX handshake bundle; slave is the stage register's view, master the
// surrounding pipeline's view.
interface ex_stage_reg_if
  import ex_stage_reg_pkg::*;
#(
  parameter int unsigned ALU_OP_W = ALU_OP_W_DEF,
  parameter int unsigned RD_W     = RD_W_DEF
);

  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] in_alu_op;
  logic                in_alu_src;
  logic                in_lui_src;
  logic [RD_W-1:0]     in_rd;
  logic                in_reg_write;

  logic                out_valid;
  logic                out_ready;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic                out_alu_src;
  logic                out_lui_src;
  logic [RD_W-1:0]     out_rd;
  logic                out_reg_write;

  modport slave (
    input  in_valid, in_alu_op, in_alu_src, in_lui_src, in_rd, in_reg_write,
    output in_ready,
    output out_valid, out_alu_op, out_alu_src, out_lui_src, out_rd, out_reg_write,
    input  out_ready
  );

  modport master (
    output in_valid, in_alu_op, in_alu_src, in_lui_src, in_rd, in_reg_write,
    input  in_ready,
    input  out_valid, out_alu_op, out_alu_src, out_lui_src, out_rd, out_reg_write,
    output out_ready
  );

endinterface

// File: rtl/ex_payload_reg.sv
// Enable-loaded payload register; reset and clear both return it to the
// bubble encoding so an empty slot always reads as a NOP.
module ex_payload_reg #(
  parameter int unsigned W         = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_stage_reg.sv
// ID/EX pipeline register built as a two-entry skid buffer so in_ready is
// registered and never depends combinationally on out_ready.
module ex_stage_reg
  import ex_stage_reg_pkg::*;
#(
  parameter int unsigned ALU_OP_W     = ALU_OP_W_DEF,
  parameter int unsigned RD_W         = RD_W_DEF,
  parameter int unsigned RESET_ALU_OP = RESET_ALU_OP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  ex_stage_reg_if.slave     bus,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned PAY_W = ALU_OP_W + RD_W + 3;
  localparam logic [PAY_W-1:0] PAY_BUBBLE =
    {ALU_OP_W'(RESET_ALU_OP), {(RD_W + 3){1'b0}}};

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   in_hs, out_hs;
  logic   main_ld, main_clr, main_sel_skid;
  logic   skid_ld, skid_clr;

  logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;

  assign in_pay = {bus.in_alu_op, bus.in_alu_src, bus.in_lui_src,
                   bus.in_rd, bus.in_reg_write};
  assign main_d = main_sel_skid ? skid_q : in_pay;

  assign {bus.out_alu_op, bus.out_alu_src, bus.out_lui_src,
          bus.out_rd, bus.out_reg_write} = main_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Occupancy transitions; flush outranks both handshakes.
  always_comb begin
    state_d       = state_q;
    main_ld       = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_ld       = 1'b0;
    skid_clr      = 1'b0;
    in_hs         = bus.in_valid & in_ready_q;
    out_hs        = out_valid_q & bus.out_ready;

    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            main_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_ld = 1'b1;
          end else if (in_hs) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (out_hs) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            main_ld       = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
            state_d       = ONE;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
          state_d  = EMPTY;
        end
      endcase
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  ex_payload_reg #(.W(PAY_W), .RESET_VAL(PAY_BUBBLE)) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (main_clr),
    .load (main_ld),
    .d    (main_d),
    .q    (main_q)
  );

  ex_payload_reg #(.W(PAY_W), .RESET_VAL(PAY_BUBBLE)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (skid_clr),
    .load (skid_ld),
    .d    (in_pay),
    .q    (skid_q)
  );

  // Saturating count of cycles presenting a bubble to EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!out_valid_q && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_stage_reg.sv
// Directed bench for ex_stage_reg: handshake ordering, flush, reset and the
// saturating bubble counter, against hand-computed expectations.
module tb_ex_stage_reg;
  import ex_stage_reg_pkg::*;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [CNT_W-1:0]  bubble_cnt;

  int unsigned n_checks;
  int unsigned n_pass;

  ex_stage_reg_if #(.ALU_OP_W(4), .RD_W(5)) ifc ();

  ex_stage_reg #(.ALU_OP_W(4), .RD_W(5), .RESET_ALU_OP(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (ifc.slave),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd,
                       input logic src, input logic lui, input logic we);
    ifc.in_valid     = v;
    ifc.in_alu_op    = op;
    ifc.in_rd        = rd;
    ifc.in_alu_src   = src;
    ifc.in_lui_src   = lui;
    ifc.in_reg_write = we;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    ifc.out_ready = 1'b0;
    idle();

    // Reset state
    step();
    step();
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
    check("rst_alu_op",    32'(ifc.out_alu_op), 32'(EX_CTRL_BUBBLE.alu_op));
    check("rst_bubble",    32'(bubble_cnt),     32'd0);
    rst = 1'b0;

    // Single entry, one-cycle latency, all payload fields carried
    drive(1'b1, 4'h3, 5'd7, 1'b1, 1'b1, 1'b1);
    ifc.out_ready = 1'b1;
    step();
    check("lat_out_valid", 32'(ifc.out_valid),     32'd1);
    check("lat_alu_op",    32'(ifc.out_alu_op),    32'h3);
    check("lat_rd",        32'(ifc.out_rd),        32'd7);
    check("lat_flags",     32'({ifc.out_alu_src, ifc.out_lui_src, ifc.out_reg_write}), 32'b111);
    idle();
    step();
    check("drain_valid",   32'(ifc.out_valid),     32'd0);
    check("drain_flags",   32'({ifc.out_alu_op, ifc.out_alu_src, ifc.out_lui_src, ifc.out_rd, ifc.out_reg_write}), 32'd0);
    check("cnt_one",       32'(bubble_cnt),        32'd1);

    // Fill to FULL with stalled EX, then drain in order
    ifc.out_ready = 1'b0;
    drive(1'b1, 4'h1, 5'd1, 1'b0, 1'b0, 1'b1);
    step();
    check("a_alu_op",      32'(ifc.out_alu_op),    32'h1);
    check("one_in_ready",  32'(ifc.in_ready),      32'd1);
    drive(1'b1, 4'h2, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    check("full_in_ready", 32'(ifc.in_ready),      32'd0);
    check("full_stable",   32'(ifc.out_alu_op),    32'h1);
    drive(1'b1, 4'h9, 5'd9, 1'b1, 1'b1, 1'b1);
    step();
    check("full_hold_op",  32'(ifc.out_alu_op),    32'h1);
    check("full_hold_rd",  32'(ifc.out_rd),        32'd1);
    idle();
    ifc.out_ready = 1'b1;
    step();
    check("b_alu_op",      32'(ifc.out_alu_op),    32'h2);
    check("b_rd",          32'(ifc.out_rd),        32'd2);
    check("b_alu_src",     32'(ifc.out_alu_src),   32'd1);
    check("b_in_ready",    32'(ifc.in_ready),      32'd1);
    step();
    check("ab_drained",    32'(ifc.out_valid),     32'd0);

    // Flush from FULL discards held entries and the same-cycle input
    ifc.out_ready = 1'b0;
    drive(1'b1, 4'h1, 5'd1, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 4'h2, 5'd2, 1'b0, 1'b0, 1'b1);
    step();
    check("pre_flush_full", 32'(ifc.in_ready),     32'd0);
    flush = 1'b1;
    drive(1'b1, 4'h5, 5'd5, 1'b0, 1'b0, 1'b1);
    step();
    check("flush_valid",   32'(ifc.out_valid),     32'd0);
    check("flush_alu_op",  32'(ifc.out_alu_op),    32'd0);
    check("flush_ready",   32'(ifc.in_ready),      32'd1);
    flush = 1'b0;
    idle();
    ifc.out_ready = 1'b1;
    step();
    check("flush_no_op5",  32'(ifc.out_valid),     32'd0);

    // ONE with simultaneous push and pop reloads main
    ifc.out_ready = 1'b0;
    drive(1'b1, 4'h4, 5'd4, 1'b0, 1'b0, 1'b0);
    step();
    check("one_op4",       32'(ifc.out_alu_op),    32'h4);
    drive(1'b1, 4'h6, 5'd6, 1'b0, 1'b1, 1'b0);
    ifc.out_ready = 1'b1;
    step();
    check("reload_op6",    32'(ifc.out_alu_op),    32'h6);
    check("reload_valid",  32'(ifc.out_valid),     32'd1);
    check("reload_ready",  32'(ifc.in_ready),      32'd1);
    idle();
    step();
    check("reload_drain",  32'(ifc.out_valid),     32'd0);

    // Flush while EMPTY only keeps in_ready high
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_empty_v", 32'(ifc.out_valid),     32'd0);
    check("flush_empty_r", 32'(ifc.in_ready),      32'd1);

    // Reset outranks handshakes mid-transfer in FULL
    ifc.out_ready = 1'b0;
    drive(1'b1, 4'h1, 5'd1, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 4'h2, 5'd2, 1'b0, 1'b0, 1'b1);
    step();
    check("pre_rst_full",  32'(ifc.in_ready),      32'd0);
    rst = 1'b1;
    ifc.out_ready = 1'b1;
    drive(1'b1, 4'h7, 5'd3, 1'b0, 1'b0, 1'b1);
    step();
    check("rstf_valid",    32'(ifc.out_valid),     32'd0);
    check("rstf_ready",    32'(ifc.in_ready),      32'd1);
    check("rstf_bubble",   32'(bubble_cnt),        32'd0);
    check("rstf_alu_op",   32'(ifc.out_alu_op),    32'd0);
    rst = 1'b0;
    idle();
    ifc.out_ready = 1'b0;

    // Saturating bubble counter: k idle edges after reset give k
    for (int i = 0; i < 65534; i++) step();
    check("cnt_fffe",      32'(bubble_cnt),        32'hFFFE);
    step();
    check("cnt_ffff",      32'(bubble_cnt),        32'hFFFF);
    for (int i = 0; i < 4465; i++) step();
    check("cnt_sat",       32'(bubble_cnt),        32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
